// File: rtl/gate_chk_pkg.sv
// Shared types and reference truth tables for the gate truth-table checker.
// Truth tables are indexed by the stimulus value: bit i is the expected output
// when the 2-input gate sees {a, b} == i.
package gate_chk_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE
    } state_t;

    localparam logic [3:0] NAND_TT = 4'b0111;
    localparam logic [3:0] AND_TT  = 4'b1000;
    localparam logic [3:0] OR_TT   = 4'b1110;
    localparam logic [3:0] NOR_TT  = 4'b0001;
    localparam logic [3:0] XOR_TT  = 4'b0110;
    localparam logic [3:0] XNOR_TT = 4'b1001;

endpackage

// File: rtl/gate_truth_table_checker_settle_counter.sv
// Loadable down-counter that times how long each stimulus row is held before
// the gate output is sampled. The zero flag marks the final settle cycle.
module settle_counter #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic [WIDTH-1:0] value,
    output logic             zero
);

    // Load has priority over decrement; reset clears the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (dec) begin
            value <= value - 1'b1;
        end
    end

    // Zero flag drives the DRIVE -> SAMPLE transition.
    always_comb begin
        zero = (value == '0);
    end

endmodule

// File: rtl/gate_truth_table_checker.sv
// Sweeps every input combination of a combinational gate in ascending order,
// samples its output after SETTLE_CYCLES and checks it against EXPECTED.
// Optional macro ABORT_ON_FAIL_EN: stop the sweep at the first mismatching row.
module gate_truth_table_checker
    import gate_chk_pkg::*;
#(
    parameter int unsigned           N_IN          = 2,
    parameter int unsigned           SETTLE_CYCLES = 2,
    parameter logic [(1<<N_IN)-1:0]  EXPECTED      = NAND_TT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   y_in,
    output logic [N_IN-1:0]        stim,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [(1<<N_IN)-1:0]   result,
    output logic [(1<<N_IN)-1:0]   err_mask
);

    localparam int unsigned       ROWS       = 1 << N_IN;
    localparam int unsigned       CNT_W      = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [N_IN-1:0]   LAST_ROW   = N_IN'(ROWS - 1);

    state_t           state;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_zero;
    logic [CNT_W-1:0] cnt_value;
    logic             y_mismatch;
    logic             last_row;
    logic             sweep_end;

    settle_counter #(
        .WIDTH (CNT_W)
    ) u_settle (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (CNT_RELOAD),
        .dec      (cnt_dec),
        .value    (cnt_value),
        .zero     (cnt_zero)
    );

    // Row comparison, end-of-sweep decision and settle-counter control.
    always_comb begin
        y_mismatch = y_in ^ EXPECTED[stim];
        last_row   = (stim == LAST_ROW);
`ifdef ABORT_ON_FAIL_EN
        sweep_end  = last_row || y_mismatch;
`else
        sweep_end  = last_row;
`endif
        cnt_load   = ((state == IDLE) && start) || ((state == SAMPLE) && !sweep_end);
        cnt_dec    = (state == DRIVE) && (cnt_value != '0);
    end

    // Sweep FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            stim     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            result   <= '0;
            err_mask <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        stim     <= '0;
                        result   <= '0;
                        err_mask <= '0;
                        pass     <= 1'b0;
                        busy     <= 1'b1;
                        state    <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (cnt_zero) begin
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    result[stim]   <= y_in;
                    err_mask[stim] <= y_mismatch;
                    if (sweep_end) begin
                        // err_mask is not yet updated here, so fold in this row's result.
                        done  <= 1'b1;
                        pass  <= ~(y_mismatch | (|err_mask));
                        state <= DONE;
                    end else begin
                        stim  <= stim + 1'b1;
                        state <= DRIVE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    stim  <= '0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Directed bench for gate_truth_table_checker: a default NAND instance whose
// gate response is selectable (true NAND, stuck-at-1, stuck-at-0) and a second
// instance configured for XOR with a one-cycle settle time.
module tb_gate_truth_table_checker;
    import gate_chk_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    // default instance
    logic       start = 1'b0;
    logic       y;
    logic [1:0] stim;
    logic       busy, done, pass;
    logic [3:0] result, err_mask;
    int         y_mode = 0;   // 0: NAND gate, 1: stuck at 1, 2: stuck at 0

    // XOR instance
    logic       start_x = 1'b0;
    logic       y_x;
    logic [1:0] stim_x;
    logic       busy_x, done_x, pass_x;
    logic [3:0] result_x, err_mask_x;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    always_comb begin
        if (y_mode == 0) y = ~&stim;
        else             y = (y_mode == 1);
        y_x = ^stim_x;
    end

    gate_truth_table_checker u_dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .y_in     (y),
        .stim     (stim),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .result   (result),
        .err_mask (err_mask)
    );

    gate_truth_table_checker #(
        .N_IN          (2),
        .SETTLE_CYCLES (1),
        .EXPECTED      (XOR_TT)
    ) u_xor (
        .clk      (clk),
        .rst      (rst),
        .start    (start_x),
        .y_in     (y_x),
        .stim     (stim_x),
        .busy     (busy_x),
        .done     (done_x),
        .pass     (pass_x),
        .result   (result_x),
        .err_mask (err_mask_x)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One sweep on the default instance: start accepted at E0, observe 20 edges.
    // repulse_at > 0 re-asserts start so that it is seen at edge E0+repulse_at.
    task automatic run_sweep(input int repulse_at, output int first_done,
                             output int done_cnt, output bit seq_ok);
        first_done = 0;
        done_cnt   = 0;
        seq_ok     = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        if (stim !== 2'd0 || busy !== 1'b1) seq_ok = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            if (n == repulse_at) start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            if (done === 1'b1) begin
                done_cnt++;
                if (first_done == 0) first_done = n;
            end else if (first_done == 0) begin
                if (stim !== 2'(n / 3) || busy !== 1'b1) seq_ok = 1'b0;
            end
        end
    endtask

    initial begin
        int  lat;
        int  dcnt;
        bit  sok;
        int  lat_x;

        // reset state
        #12;
        check("reset_outputs", {19'd0, stim, busy, done, pass, result, err_mask}, 32'd0);
        check("reset_outputs_xor", {19'd0, stim_x, busy_x, done_x, pass_x, result_x, err_mask_x}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // correct NAND gate
        y_mode = 0;
        run_sweep(0, lat, dcnt, sok);
        check("nand_latency", lat, 12);
        check("nand_done_count", dcnt, 1);
        check("nand_stim_busy_seq", {31'd0, sok}, 1);
        check("nand_result", {28'd0, result}, 32'b0111);
        check("nand_err_mask", {28'd0, err_mask}, 0);
        check("nand_pass", {31'd0, pass}, 1);
        check("nand_idle_after", {29'd0, stim, busy}, 0);

        // reset in the middle of a sweep
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midreset_async_clear", {19'd0, stim, busy, done, pass, result, err_mask}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        dcnt = 0;
        for (int n = 0; n < 15; n++) begin
            @(posedge clk);
            #1 if (done === 1'b1) dcnt++;
        end
        check("midreset_no_done", dcnt, 0);
        check("midreset_busy_low", {31'd0, busy}, 0);
        run_sweep(0, lat, dcnt, sok);
        check("after_reset_latency", lat, 12);
        check("after_reset_pass", {31'd0, pass}, 1);

        // start re-pulsed while busy
        run_sweep(4, lat, dcnt, sok);
        check("repulse_latency", lat, 12);
        check("repulse_done_count", dcnt, 1);
        check("repulse_stim_seq", {31'd0, sok}, 1);

        // output stuck at 1: only row 3 disagrees with NAND
        y_mode = 1;
        run_sweep(0, lat, dcnt, sok);
        check("stuck1_latency", lat, 12);
        check("stuck1_result", {28'd0, result}, 32'b1111);
        check("stuck1_err_mask", {28'd0, err_mask}, 32'b1000);
        check("stuck1_pass", {31'd0, pass}, 0);

        // output stuck at 0: rows 0..2 disagree
        y_mode = 2;
        run_sweep(0, lat, dcnt, sok);
`ifdef ABORT_ON_FAIL_EN
        check("stuck0_latency", lat, 3);
        check("stuck0_err_mask", {28'd0, err_mask}, 32'b0001);
`else
        check("stuck0_latency", lat, 12);
        check("stuck0_err_mask", {28'd0, err_mask}, 32'b0111);
`endif
        check("stuck0_result", {28'd0, result}, 0);
        check("stuck0_pass", {31'd0, pass}, 0);
        check("stuck0_done_count", dcnt, 1);

        // XOR instance, SETTLE_CYCLES = 1
        @(negedge clk);
        start_x = 1'b1;
        @(posedge clk);
        #1 start_x = 1'b0;
        lat_x = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1 if (done_x === 1'b1 && lat_x == 0) lat_x = n;
        end
        check("xor_latency", lat_x, 8);
        check("xor_result", {28'd0, result_x}, 32'b0110);
        check("xor_err_mask", {28'd0, err_mask_x}, 0);
        check("xor_pass", {31'd0, pass_x}, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
